// File: rtl/rowbias_shuffler.sv
// rowbias_shuffler: one-hot row bias pool with LFSR-driven Fisher-Yates reshuffle
module rowbias_shuffler #(
  parameter int W = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  input  logic              shuffle_req,
  output logic              shuffle_busy,
  output logic              shuffle_done,
  input  logic              update,
  input  logic [W-1:0]      rqindex,
  output logic [W-1:0]      busvalue
);
  localparam int IW = $clog2(W);
  typedef enum logic {IDLE, SHUFFLE} state_t;
  state_t state, state_next;
  logic [W-1:0] pool [W];
  logic [LFSR_W-1:0] lfsr, lfsr_adv;
  logic [IW-1:0] i_cnt, j;
  logic accept, last_step;
  logic [W-1:0] lookup, pool_i, pool_j;
  always_comb begin
    j = lfsr[IW-1:0];
    accept = j <= i_cnt;
    last_step = state == SHUFFLE && accept && i_cnt == IW'(1);
    lfsr_adv = lfsr[0] ? (lfsr >> 1) ^ TAPS : lfsr >> 1;
    state_next = last_step ? IDLE :
                 (state == IDLE && shuffle_req && !seed_load) ? SHUFFLE : state;
  end
  // Descending scan so the lowest set request bit wins
  always_comb begin
    lookup = '0;
    pool_i = '0;
    pool_j = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (rqindex[k]) lookup = pool[k];
      if (IW'(k) == i_cnt) pool_i = pool[k];
      if (IW'(k) == j) pool_j = pool[k];
    end
  end
  assign shuffle_busy = state == SHUFFLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < W; k++) pool[k] <= W'(1) << k;
      lfsr <= SEED;
      busvalue <= '0;
      shuffle_done <= 1'b0;
      i_cnt <= IW'(W - 1);
    end else begin
      shuffle_done <= last_step;
      if (state == IDLE) begin
        if (seed_load) lfsr <= (seed_value == '0) ? SEED : seed_value;
        else if (shuffle_req) i_cnt <= IW'(W - 1);
        if (update) busvalue <= lookup;
      end else begin
        lfsr <= lfsr_adv;
        if (accept) begin
          i_cnt <= i_cnt - IW'(1);
          for (int k = 0; k < W; k++)
            if (IW'(k) == i_cnt) pool[k] <= pool_j;
            else if (IW'(k) == j) pool[k] <= pool_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_rowbias_shuffler.sv
// tb_rowbias_shuffler: randomized scoreboard bench against a Fisher-Yates reference model
module tb_rowbias_shuffler;
  localparam int W = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int JMASK = (1 << $clog2(W)) - 1;
  logic clock = 1'b0, reset = 1'b0, seed_load = 1'b0, shuffle_req = 1'b0, update = 1'b0;
  logic [15:0] seed_value = '0;
  logic [W-1:0] rqindex = '0, busvalue;
  logic shuffle_busy, shuffle_done;
  rowbias_shuffler #(.W(W)) dut (
    .clock(clock), .reset(reset), .seed_load(seed_load), .seed_value(seed_value),
    .shuffle_req(shuffle_req), .shuffle_busy(shuffle_busy), .shuffle_done(shuffle_done),
    .update(update), .rqindex(rqindex), .busvalue(busvalue)
  );
  always #5 clock = ~clock;
  typedef struct {int cyc; int kind; logic [W-1:0] exp;} chk_t;
  chk_t q[$];
  int cyc = 0, tests = 0, fails = 0;
  logic [W-1:0] mpool [W];
  logic [15:0] mlfsr;
  logic [W-1:0] last_bus;
  always @(posedge clock) cyc++;
  // Monitor: every pending expectation stamped for this edge is compared
  always @(posedge clock) begin
    logic [W-1:0] act;
    #1;
    for (int idx = q.size() - 1; idx >= 0; idx--)
      if (q[idx].cyc == cyc) begin
        act = q[idx].kind == 0 ? busvalue : q[idx].kind == 1 ? W'(shuffle_busy) : W'(shuffle_done);
        tests++;
        if (act !== q[idx].exp) begin
          fails++;
          $display("FAIL %s cyc=%0d got=%b want=%b",
                   q[idx].kind == 0 ? "busvalue" : q[idx].kind == 1 ? "shuffle_busy" : "shuffle_done",
                   cyc, act, q[idx].exp);
        end
        q.delete(idx);
      end
  end
  task automatic expect_at(input int c, input int kind, input logic [W-1:0] e);
    chk_t t;
    t.cyc = c; t.kind = kind; t.exp = e;
    q.push_back(t);
  endtask
  function automatic logic [15:0] adv(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < W; k++) mpool[k] = W'(1) << k;
    mlfsr = SEED;
    last_bus = '0;
  endtask
  // Fisher-Yates with rejection; returns number of cycles spent shuffling
  task automatic model_shuffle(output int n);
    int i, jj;
    logic [W-1:0] t;
    i = W - 1;
    n = 0;
    forever begin
      jj = int'(mlfsr) & JMASK;
      n++;
      mlfsr = adv(mlfsr);
      if (jj <= i) begin
        t = mpool[i]; mpool[i] = mpool[jj]; mpool[jj] = t;
        if (i == 1) break;
        i--;
      end
    end
  endtask
  function automatic logic [W-1:0] model_lookup(input logic [W-1:0] r);
    for (int k = 0; k < W; k++) if (r[k]) return mpool[k];
    return '0;
  endfunction
  task automatic do_update(input logic [W-1:0] r);
    @(negedge clock);
    update = 1'b1; rqindex = r;
    last_bus = model_lookup(r);
    expect_at(cyc + 1, 0, last_bus);
    @(negedge clock);
    update = 1'b0;
  endtask
  task automatic check_pool();
    for (int k = 0; k < W; k++) do_update(W'(1) << k);
    do_update('0);
    for (int k = 0; k < 4; k++) do_update(W'($urandom_range(0, (1 << W) - 1)));
  endtask
  task automatic do_shuffle(input logic [15:0] s, input bit load, input bit same, input bit disturb);
    int c, n;
    if (load) begin
      @(negedge clock);
      seed_load = 1'b1; seed_value = s; shuffle_req = same;
      mlfsr = (s == 0) ? SEED : s;
      expect_at(cyc + 1, 1, '0);
      @(negedge clock);
      seed_load = 1'b0; shuffle_req = 1'b0;
    end
    @(negedge clock);
    shuffle_req = 1'b1;
    c = cyc;
    model_shuffle(n);
    expect_at(c + 1, 2, '0);
    for (int k = 1; k <= n; k++) expect_at(c + k, 1, W'(1));
    expect_at(c + n + 1, 1, '0);
    expect_at(c + n + 1, 2, W'(1));
    expect_at(c + n + 2, 2, '0);
    expect_at(c + n + 3, 2, '0);
    @(negedge clock);
    shuffle_req = 1'b0;
    if (disturb) begin
      update = 1'b1; rqindex = W'(1); shuffle_req = 1'b1;
      seed_load = 1'b1; seed_value = 16'($urandom);
      expect_at(cyc + 1, 0, last_bus);
      @(negedge clock);
      update = 1'b0; shuffle_req = 1'b0; seed_load = 1'b0;
    end
    while (cyc < c + n + 3) @(negedge clock);
  endtask
  initial begin
    int n;
    model_reset();
    expect_at(1, 0, '0);
    expect_at(1, 1, '0);
    expect_at(1, 2, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check_pool();
    do_shuffle(16'h1234, 1'b1, 1'b1, 1'b0);
    check_pool();
    do_shuffle(16'h0, 1'b0, 1'b0, 1'b1);
    check_pool();
    // Reset while shuffling: state must return to identity/SEED
    do_update(W'(4));
    @(negedge clock);
    seed_load = 1'b1; seed_value = 16'h7777;
    @(negedge clock);
    seed_load = 1'b0; shuffle_req = 1'b1;
    @(negedge clock);
    shuffle_req = 1'b0;
    repeat (2) @(negedge clock);
    q.delete();
    reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (shuffle_busy !== 1'b0 || busvalue !== '0) begin
      fails++;
      $display("FAIL async_reset busy=%b bus=%b want busy=0 bus=0", shuffle_busy, busvalue);
    end
    @(negedge clock);
    reset = 1'b1;
    check_pool();
    do_shuffle(16'h0, 1'b1, 1'b0, 1'b0);
    check_pool();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    do_shuffle(16'h0, 1'b0, 1'b0, 1'b0);
    check_pool();
    do_shuffle(16'hBEEF, 1'b1, 1'b0, 1'b0);
    check_pool();
    do_shuffle(16'hBEEF, 1'b1, 1'b0, 1'b0);
    check_pool();
    for (int r = 0; r < 4; r++) begin
      do_shuffle(16'($urandom_range(1, 16'hFFFF)), 1'b1, r[0], r[1]);
      check_pool();
    end
    repeat (3) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_checks got=%0d want=0", q.size());
    end
    n = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
